bsmac: RTL and testbench
========================

Name: bsmac

Overview:
- Signed binary-serial multiply-accumulate stage, directly downstream of the PE weight register.
- Consumes the held weight word and an input activation, then adds their product to an incoming partial sum.
- Retires one activation bit per cycle using shift-add; the activation MSB is subtracted (two's complement).
- Produces a registered partial sum with a one-cycle done pulse, for forwarding to the next PE row.

Parameters:
- WIDTH, 16, width of weight and activation operands (signed); legal range ≥ 2.
- ACC_WIDTH, 32, width of partial-sum input, output and internal accumulator (signed); must be ≥ 2*WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  stage enable; low freezes all state (stall).
- clr  input  1  synchronous clear; highest priority after reset.
- i_start  input  1  request a new MAC; sampled only when o_busy=0 and en=1.
- i_ifm  input  WIDTH  signed input activation.
- i_wght  input  WIDTH  signed weight, driven from the weight register output.
- i_psum  input  ACC_WIDTH  signed incoming partial sum.
- o_busy  output  1  high while in MUL state.
- o_done  output  1  one-cycle pulse; o_psum has just been updated.
- o_psum  output  ACC_WIDTH  signed result = i_psum + i_ifm*i_wght, mod 2^ACC_WIDTH.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, counter=0, accumulator=0, captured operands=0.
  - o_psum=0, o_done=0, o_busy=0.
- Priority at each edge: rst_n > clr > en=0 (hold) > normal operation.
- clr=1 (synchronous):
  - Same values as reset; any in-flight operation is aborted and i_start is ignored that cycle.
- en=0:
  - State, counter, accumulator, operand registers and o_psum hold.
  - o_done holds its value; a pulse in progress is extended until the next enabled edge.
- States: IDLE, MUL, DONE.
  - IDLE or DONE, with i_start=1 and en=1 at an edge:
    - Capture i_ifm and i_wght.
    - Accumulator ← i_psum.
    - counter ← 0; go to MUL.
  - IDLE or DONE, i_start=0: go to or stay in IDLE.
  - MUL, each enabled edge, processing bit k = counter of the captured activation:
    - bit=1 and k<WIDTH-1: accumulator += sign_extend(wght) << k.
    - bit=1 and k=WIDTH-1: accumulator -= sign_extend(wght) << k.
    - bit=0: no change.
    - counter increments.
    - At k=WIDTH-1, instead of incrementing: o_psum ← final accumulator value, o_done ← 1, go to DONE, counter ← 0.
  - DONE: o_done=1 for exactly this one enabled cycle, then clears; o_psum holds until the next completion or clear.
- Latency and throughput:
  - o_done is visible immediately after the WIDTH-th enabled edge following the edge that sampled i_start.
  - With i_start held high, back-to-back operations complete every WIDTH+1 enabled cycles.
- i_start while o_busy=1 is ignored; no queuing.
- Operand changes after capture do not affect the result.
- Arithmetic:
  - All arithmetic in ACC_WIDTH two's complement; overflow wraps silently, no saturation.
  - The product itself never overflows, since ACC_WIDTH ≥ 2*WIDTH.
- o_busy = (state==MUL), driven from a register, not from inputs.

Test Plan:
- Basic multiply: WIDTH=16, ifm=3, wght=5, psum=0, start pulse, en=1.
  - o_busy high for 16 cycles, then o_done for 1 cycle, o_psum=15.
  - o_psum holds 15 afterwards.
- Sign handling:
  - ifm=-32768, wght=-32768, psum=0 → o_psum=1073741824.
  - ifm=-1, wght=7, psum=100 → o_psum=93.
- Wrap-around: ifm=1, wght=1, psum=2147483647 → o_psum=-2147483648, no error flag.
- Stall: en=0 for 3 cycles starting at counter=5 of a 3×5 operation.
  - o_done appears 3 cycles later than unstalled; o_psum=15.
  - Change i_ifm during the stall → result unchanged.
- Clear mid-operation: clr=1 at counter=8 → next cycle o_busy=0, o_psum=0, no o_done.
  - A new start (2×2, psum=1) then yields o_psum=5.
- Start while busy and back-to-back:
  - i_start held high across two operations (ifm=2/wght=3, then ifm=-4/wght=4, psum=0 each).
  - Starts during MUL are ignored.
  - Results are 6 then -16, done pulses 17 cycles apart.
- Async reset mid-MUL: all outputs go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/bsmac.sv
// rtl/bsmac.sv - signed binary-serial multiply-accumulate stage
//
// Computes o_psum = i_psum + i_ifm * i_wght (mod 2^ACC_WIDTH), retiring one
// activation bit per enabled cycle with shift-add. The activation MSB carries
// negative weight, so its partial product is subtracted.
//
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset
//   en       - stage enable; low freezes all state
//   clr      - synchronous clear, aborts any operation in flight
//   i_start  - start request, sampled when idle/done and enabled
//   i_ifm    - signed activation (WIDTH)
//   i_wght   - signed weight (WIDTH)
//   i_psum   - signed incoming partial sum (ACC_WIDTH)
//   o_busy   - high while multiplying
//   o_done   - one enabled-cycle pulse when o_psum updates
//   o_psum   - registered signed result (ACC_WIDTH)
module bsmac #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clr,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_ifm,
    input  logic [WIDTH-1:0]     i_wght,
    input  logic [ACC_WIDTH-1:0] i_psum,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [ACC_WIDTH-1:0] o_psum
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [ACC_WIDTH-1:0] acc;
    logic [WIDTH-1:0]     ifm_q;
    logic [WIDTH-1:0]     wght_q;

    logic [ACC_WIDTH-1:0] wght_ext;
    logic [ACC_WIDTH-1:0] addend;
    logic [ACC_WIDTH-1:0] acc_next;
    logic                 last_bit;

    // Partial product for the current activation bit. The MSB term is
    // subtracted because it has weight -2^(WIDTH-1) in two's complement.
    always_comb begin
        wght_ext = {{(ACC_WIDTH-WIDTH){wght_q[WIDTH-1]}}, wght_q};
        addend   = wght_ext << cnt;
        last_bit = (cnt == CW'(WIDTH-1));
        acc_next = acc;
        if (ifm_q[cnt]) begin
            if (last_bit) begin
                acc_next = acc - addend;
            end else begin
                acc_next = acc + addend;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            ifm_q  <= '0;
            wght_q <= '0;
            o_psum <= '0;
            o_done <= 1'b0;
            o_busy <= 1'b0;
        end else if (clr) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            ifm_q  <= '0;
            wght_q <= '0;
            o_psum <= '0;
            o_done <= 1'b0;
            o_busy <= 1'b0;
        end else if (en) begin
            case (state)
                MUL: begin
                    acc <= acc_next;
                    if (last_bit) begin
                        o_psum <= acc_next;
                        o_done <= 1'b1;
                        o_busy <= 1'b0;
                        cnt    <= '0;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE behave alike; the done pulse ends here.
                    o_done <= 1'b0;
                    if (i_start) begin
                        ifm_q  <= i_ifm;
                        wght_q <= i_wght;
                        acc    <= i_psum;
                        cnt    <= '0;
                        o_busy <= 1'b1;
                        state  <= MUL;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bsmac.sv
// tb/tb_bsmac.sv - self-checking testbench for bsmac
module tb_bsmac;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        clr;
    logic        i_start;
    logic [15:0] i_ifm;
    logic [15:0] i_wght;
    logic [31:0] i_psum;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_psum;

    int tests;
    int fails;

    bsmac #(.WIDTH(16), .ACC_WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .clr    (clr),
        .i_start(i_start),
        .i_ifm  (i_ifm),
        .i_wght (i_wght),
        .i_psum (i_psum),
        .o_busy (o_busy),
        .o_done (o_done),
        .o_psum (o_psum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ifm;
        logic [15:0] wght;
        logic [31:0] psum;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic start_op(input logic [15:0] ifm, input logic [15:0] wght, input logic [31:0] psum);
        @(negedge clk);
        i_ifm   = ifm;
        i_wght  = wght;
        i_psum  = psum;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        while (!o_done && lat < 100) begin
            if (o_busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    int lat;
    int bc;
    int t_first;
    int t_second;
    int cyc;
    logic saw_done;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        tests   = 0;
        fails   = 0;
        cyc     = 0;
        rst_n   = 1'b0;
        en      = 1'b1;
        clr     = 1'b0;
        i_start = 1'b0;
        i_ifm   = '0;
        i_wght  = '0;
        i_psum  = '0;

        vecs[0] = '{16'sd3,      16'sd5,      32'sd0,          32'sd15};
        vecs[1] = '{16'h8000,    16'h8000,    32'sd0,          32'sd1073741824};
        vecs[2] = '{-16'sd1,     16'sd7,      32'sd100,        32'sd93};
        vecs[3] = '{16'sd1,      16'sd1,      32'h7fff_ffff,   32'h8000_0000};
        vecs[4] = '{-16'sd5,     -16'sd6,     -32'sd10,        32'sd20};
        vecs[5] = '{16'sd12345,  -16'sd2,     32'sd7,          -32'sd24683};
        vecs[6] = '{16'sd32767,  16'sd32767,  32'sd0,          32'sd1073676289};

        // Reset state
        #12;
        check("reset_busy", {31'b0, o_busy}, 32'd0);
        check("reset_done", {31'b0, o_done}, 32'd0);
        check("reset_psum", o_psum, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 7; i++) begin
            start_op(vecs[i].ifm, vecs[i].wght, vecs[i].psum);
            wait_done(lat, bc);
            check($sformatf("vec%0d_latency", i), lat, 32'd16);
            check($sformatf("vec%0d_busy_cycles", i), bc, 32'd16);
            check($sformatf("vec%0d_psum", i), o_psum, vecs[i].exp);
            @(negedge clk);
            check($sformatf("vec%0d_done_cleared", i), {31'b0, o_done}, 32'd0);
            check($sformatf("vec%0d_psum_hold", i), o_psum, vecs[i].exp);
        end

        // Stall at counter=5 for three cycles, operand change during the stall
        start_op(16'sd3, 16'sd5, 32'sd0);
        repeat (5) @(negedge clk);
        en     = 1'b0;
        i_ifm  = 16'sd99;
        i_wght = 16'sd1;
        repeat (3) @(negedge clk);
        check("stall_busy", {31'b0, o_busy}, 32'd1);
        check("stall_no_done", {31'b0, o_done}, 32'd0);
        en = 1'b1;
        wait_done(lat, bc);
        check("stall_remaining_latency", lat, 32'd11);
        check("stall_psum", o_psum, 32'd15);
        en = 1'b0;
        repeat (2) @(negedge clk);
        check("stall_done_extended", {31'b0, o_done}, 32'd1);
        en = 1'b1;
        @(negedge clk);
        check("stall_done_end", {31'b0, o_done}, 32'd0);

        // Clear at counter=8
        start_op(16'sd3, 16'sd5, 32'sd0);
        repeat (8) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_busy", {31'b0, o_busy}, 32'd0);
        check("clr_psum", o_psum, 32'd0);
        check("clr_done", {31'b0, o_done}, 32'd0);
        saw_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (o_done) saw_done = 1'b1;
        end
        check("clr_no_late_done", {31'b0, saw_done}, 32'd0);
        start_op(16'sd2, 16'sd2, 32'sd1);
        wait_done(lat, bc);
        check("clr_restart_latency", lat, 32'd16);
        check("clr_restart_psum", o_psum, 32'd5);
        @(negedge clk);

        // Back-to-back with i_start held high
        @(negedge clk);
        i_ifm   = 16'sd2;
        i_wght  = 16'sd3;
        i_psum  = 32'sd0;
        i_start = 1'b1;
        @(negedge clk);
        i_ifm   = -16'sd4;
        i_wght  = 16'sd4;
        wait_done(lat, bc);
        t_first = cyc;
        check("b2b_first_psum", o_psum, 32'sd6);
        @(negedge clk);
        wait_done(lat, bc);
        t_second = cyc;
        i_start  = 1'b0;
        check("b2b_second_psum", o_psum, -32'sd16);
        check("b2b_spacing", t_second - t_first, 32'd17);

        // Asynchronous reset mid-operation
        @(negedge clk);
        start_op(16'sd1, 16'sd1, 32'sd0);
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_busy", {31'b0, o_busy}, 32'd0);
        check("areset_done", {31'b0, o_done}, 32'd0);
        check("areset_psum", o_psum, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start_op(16'sd3, 16'sd5, 32'sd0);
        wait_done(lat, bc);
        check("post_reset_psum", o_psum, 32'sd15);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
